fetch_ctrl: RTL and testbench

//   Sequences the instruction memory: owns the PC, issues read requests to the instruction BRAM
//   and captures each returned word. Each word is tagged with its PC and buffered in a small FIFO.

---
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues BRAM reads, buffers tagged words
// in a small FIFO and presents them to decode over valid/ready.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  input  logic              out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Handshake: decode takes the head on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the head is held while not accepted.

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             squash_q, squash_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W:0]   used;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !squash_q && !redirect_valid;
  assign imem_addr = pc_q[ADDR_W-1:0];
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;

  // Credit counts the head leaving this cycle so a full-rate stream needs only two slots.
  assign used     = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign imem_req = rst_n && !redirect_valid && (used < (CNT_W+1)'(DEPTH));

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    squash_d   = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      squash_d = inflight_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: out_* are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; memory returns word (addr>>2)+1 one cycle after a request.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .ADDR_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) imem_rdata <= '0;
    else if (imem_req) imem_rdata <= 32'(imem_addr >> 2) + 32'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 after reset release.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req c=%0d got=%b exp=1", c, imem_req); end
      checks++; if (imem_addr !== 8'(4 * c)) begin errors++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, imem_addr, 8'(4 * c)); end
      if (c < 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_pc !== 32'(4 * (c - 2))) begin errors++; $display("FAIL stream_pc c=%0d got=%h exp=%h", c, out_pc, 32'(4 * (c - 2))); end
        checks++; if (out_inst !== 32'(c - 1)) begin errors++; $display("FAIL stream_inst c=%0d got=%h exp=%h", c, out_inst, 32'(c - 1)); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL stall_req0 got=%b/%h exp=1/00", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin errors++; $display("FAIL stall_req1 got=%b/%h exp=1/04", imem_req, imem_addr); end
    for (int c = 2; c < 6; c++) begin
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq c=%0d got=%b exp=0", c, imem_req); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1) begin
        errors++; $display("FAIL stall_head c=%0d got=%b/%h/%h exp=1/0/1", c, out_valid, out_pc, out_inst); end
    end
    step();
    out_ready = 1'b1;
    #1;
    checks++; if (out_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 8'h08) begin
      errors++; $display("FAIL stall_resume0 got=%h/%b/%h exp=0/1/08", out_pc, imem_req, imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h2) begin
      errors++; $display("FAIL stall_resume1 got=%b/%h/%h exp=1/4/2", out_valid, out_pc, out_inst); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== 32'h3) begin
      errors++; $display("FAIL stall_resume2 got=%b/%h/%h exp=1/8/3", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noreq got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin errors++; $display("FAIL redir_head got=%b/%h exp=1/8", out_valid, out_pc); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL redir_addr got=%b/%h exp=1/40", imem_req, imem_addr); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_stale got=%b/%h exp=0", out_valid, out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h11) begin
      errors++; $display("FAIL redir_first got=%b/%h/%h exp=1/40/11", out_valid, out_pc, out_inst); end
    step();
    checks++; if (out_pc !== 32'h44 || out_inst !== 32'h12) begin errors++; $display("FAIL redir_second got=%h/%h exp=44/12", out_pc, out_inst); end
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    repeat (4) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL hs_head got=%b/%h exp=1/0", out_valid, out_pc); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_flush got=%b/%h exp=0", out_valid, out_pc); end
    checks++; if (imem_addr !== 8'h80) begin errors++; $display("FAIL hs_addr got=%h exp=80", imem_addr); end
    repeat (2) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_inst !== 32'h21) begin
      errors++; $display("FAIL hs_next got=%b/%h/%h exp=1/80/21", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h40) begin errors++; $display("FAIL misal_addr got=%h exp=40", imem_addr); end
    repeat (2) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h11) begin
      errors++; $display("FAIL misal_out got=%b/%h/%h exp=1/40/11", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFC;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFC) begin errors++; $display("FAIL wrap_fc got=%b/%h exp=1/fc", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_00 got=%b/%h exp=1/00", imem_req, imem_addr); end
    step();
    checks++; if (out_pc !== 32'hFC || out_inst !== 32'h40) begin errors++; $display("FAIL wrap_out0 got=%h/%h exp=fc/40", out_pc, out_inst); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h1) begin
      errors++; $display("FAIL wrap_out1 got=%b/%h/%h exp=1/100/1", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL async_zero got=%b/%b/%h/%h exp=0/0/0/0", imem_req, out_valid, out_pc, out_inst); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_restart got=%b/%h/%b exp=1/00/0", imem_req, imem_addr, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h04) begin errors++; $display("FAIL async_c1 got=%b/%h exp=0/04", out_valid, imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1) begin
      errors++; $display("FAIL async_c2 got=%b/%h/%h exp=1/0/1", out_valid, out_pc, out_inst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_handshake();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout after 100000 time units");
    $fatal(1);
  end

endmodule
